// File: rtl/wb_timer_pkg.sv
// rtl/wb_timer_pkg.sv - shared register map constants for the Wishbone timer bank
package wb_timer_pkg;

    // Per-channel register index, taken from wb_adr_i[1:0]
    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_RELOAD = 2'd1,
        REG_COUNT  = 2'd2,
        REG_STAT   = 2'd3
    } reg_idx_t;

    // CTRL bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int CTRL_IE      = 2;
    localparam int PRESC_LSB    = 8;
    localparam int PRESC_W      = 8;

    // STAT bit positions
    localparam int STAT_EXP     = 0;

    typedef logic [PRESC_W-1:0] presc_t;

endpackage

// File: rtl/wb_timer_channel.sv
// rtl/wb_timer_channel.sv - one prescaled down-counter channel with sticky maskable expiry
module wb_timer_channel
    import wb_timer_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr,
    input  logic [1:0]              reg_idx,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [SELECT_WIDTH-1:0] sel,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    irq
);

    logic                  en, oneshot, ie;
    presc_t                presc;
    presc_t                presc_cnt;
    logic [DATA_WIDTH-1:0] reload;
    logic [DATA_WIDTH-1:0] count;
    logic                  expired;

    logic                  en_n, oneshot_n, ie_n, expired_n;
    presc_t                presc_n;
    logic [DATA_WIDTH-1:0] ctrl_q, ctrl_new;
    logic                  ctrl_wr, reload_wr, count_wr, stat_wr;
    logic                  tick, expire, stat_clr;

    // Byte-lane merge of a bus write onto the current register value
    function automatic logic [DATA_WIDTH-1:0] merge(
        input logic [DATA_WIDTH-1:0]   old_v,
        input logic [DATA_WIDTH-1:0]   new_v,
        input logic [SELECT_WIDTH-1:0] be
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_v;
        for (int b = 0; b < SELECT_WIDTH; b++) begin
            if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

    assign ctrl_wr   = wr && (reg_idx == REG_CTRL);
    assign reload_wr = wr && (reg_idx == REG_RELOAD);
    assign count_wr  = wr && (reg_idx == REG_COUNT);
    assign stat_wr   = wr && (reg_idx == REG_STAT);

    // A tick still fires on a CTRL write cycle; the write only restarts the prescaler
    assign tick     = en && (presc_cnt == presc);
    assign expire   = tick && (count == '0) && !count_wr;
    assign stat_clr = stat_wr && sel[0] && wdata[STAT_EXP];
    assign ctrl_new = merge(ctrl_q, wdata, sel);

    // CTRL image with unused bits forced to zero
    always_comb begin
        ctrl_q                         = '0;
        ctrl_q[CTRL_EN]                = en;
        ctrl_q[CTRL_ONESHOT]           = oneshot;
        ctrl_q[CTRL_IE]                = ie;
        ctrl_q[PRESC_LSB +: PRESC_W]   = presc;
    end

    // Next CTRL/STAT: bus write beats one-shot auto-disable, expiry beats W1C
    always_comb begin
        en_n      = en;
        oneshot_n = oneshot;
        ie_n      = ie;
        presc_n   = presc;
        if (expire && oneshot) en_n = 1'b0;
        if (ctrl_wr) begin
            en_n      = ctrl_new[CTRL_EN];
            oneshot_n = ctrl_new[CTRL_ONESHOT];
            ie_n      = ctrl_new[CTRL_IE];
            presc_n   = ctrl_new[PRESC_LSB +: PRESC_W];
        end
        expired_n = expired;
        if (stat_clr) expired_n = 1'b0;
        if (expire)   expired_n = 1'b1;
    end

    // Register state, prescaler and counter update
    always_ff @(posedge clk) begin
        if (rst) begin
            en        <= 1'b0;
            oneshot   <= 1'b0;
            ie        <= 1'b0;
            presc     <= '0;
            presc_cnt <= '0;
            reload    <= '0;
            count     <= '0;
            expired   <= 1'b0;
            irq       <= 1'b0;
        end else begin
            en      <= en_n;
            oneshot <= oneshot_n;
            ie      <= ie_n;
            presc   <= presc_n;
            expired <= expired_n;
            irq     <= expired_n & ie_n;

            if (ctrl_wr || !en || tick) presc_cnt <= '0;
            else                        presc_cnt <= presc_cnt + 1'b1;

            if (reload_wr) reload <= merge(reload, wdata, sel);

            if (count_wr) begin
                count <= merge(count, wdata, sel);
            end else if (tick) begin
                if (count != '0)   count <= count - 1'b1;
                else if (!oneshot) count <= reload;
            end
        end
    end

    // Combinational register read for the top-level read mux
    always_comb begin
        rdata = '0;
        case (reg_idx)
            REG_CTRL:   rdata = ctrl_q;
            REG_RELOAD: rdata = reload;
            REG_COUNT:  rdata = count;
            default:    rdata[STAT_EXP] = expired;
        endcase
    end

endmodule

// File: rtl/wb_timer_bank.sv
// rtl/wb_timer_bank.sv - multi-channel Wishbone timer bank: decode, ack/err and read mux
module wb_timer_bank
    import wb_timer_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_CH       = 4,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [5:0]              wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic                    wb_we_i,
    input  logic [SELECT_WIDTH-1:0] wb_sel_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_cyc_i,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    output logic                    wb_rty_o,
    output logic [NUM_CH-1:0]       irq_o
);

    logic [3:0]            ch;
    logic [1:0]            reg_idx;
    logic                  accept;
    logic                  in_range;
    logic                  wr_ok;
    logic [DATA_WIDTH-1:0] ch_rdata [NUM_CH];
    logic [DATA_WIDTH-1:0] rd_mux;

    assign ch       = wb_adr_i[5:2];
    assign reg_idx  = wb_adr_i[1:0];
    // Holding off while ack/err is high limits the bus to one transfer every 2 cycles
    assign accept   = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign in_range = ({28'd0, ch} < NUM_CH);
    assign wr_ok    = accept & wb_we_i & in_range;
    assign wb_rty_o = 1'b0;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        wb_timer_channel #(
            .DATA_WIDTH   (DATA_WIDTH),
            .SELECT_WIDTH (SELECT_WIDTH)
        ) u_ch (
            .clk     (i_clk),
            .rst     (i_rst),
            .wr      (wr_ok && (ch == 4'(g))),
            .reg_idx (reg_idx),
            .wdata   (wb_dat_i),
            .sel     (wb_sel_i),
            .rdata   (ch_rdata[g]),
            .irq     (irq_o[g])
        );
    end

    // Select the addressed channel's register; out-of-range channels read 0
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch == 4'(i)) rd_mux = ch_rdata[i];
        end
    end

    // Single-cycle ack/err pulse with read data captured in the request cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= accept & in_range;
            wb_err_o <= accept & ~in_range;
            if (accept) wb_dat_o <= (in_range && !wb_we_i) ? rd_mux : '0;
        end
    end

endmodule

// File: tb/tb_wb_timer_bank.sv
// tb/tb_wb_timer_bank.sv - directed self-checking bench for wb_timer_bank
module tb_wb_timer_bank;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [5:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;
    logic [3:0]  irq_o;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] q;
    logic [3:0]  irq_at_ack;

    wb_timer_bank #(
        .DATA_WIDTH (32),
        .NUM_CH     (4)
    ) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_we_i  (wb_we_i),
        .wb_sel_i (wb_sel_i),
        .wb_stb_i (wb_stb_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_ack_o (wb_ack_o),
        .wb_err_o (wb_err_o),
        .wb_rty_o (wb_rty_o),
        .irq_o    (irq_o)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus transfer: request accepted on the next edge, response sampled 1ns later,
    // then one idle cycle that must show the response pulse has dropped.
    task automatic xfer(input logic we, input logic [5:0] adr, input logic [31:0] d,
                        input logic [3:0] sel, input logic exp_err, output logic [31:0] data);
        wb_adr_i = adr;
        wb_dat_i = d;
        wb_sel_i = sel;
        wb_we_i  = we;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        @(posedge i_clk); #1;
        check("ack", {31'd0, wb_ack_o}, {31'd0, ~exp_err});
        check("err", {31'd0, wb_err_o}, {31'd0, exp_err});
        data       = wb_dat_o;
        irq_at_ack = irq_o;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        @(posedge i_clk); #1;
        check("single_pulse", {30'd0, wb_ack_o, wb_err_o}, 32'd0);
    endtask

    task automatic wr(input logic [5:0] adr, input logic [31:0] d);
        xfer(1'b1, adr, d, 4'hF, 1'b0, q);
    endtask

    task automatic wr_sel(input logic [5:0] adr, input logic [31:0] d, input logic [3:0] sel);
        xfer(1'b1, adr, d, sel, 1'b0, q);
    endtask

    task automatic rd(input string tag, input logic [5:0] adr, input logic [31:0] exp);
        xfer(1'b0, adr, 32'd0, 4'hF, 1'b0, q);
        check(tag, q, exp);
    endtask

    task automatic irq_is(input string tag, input int idx, input logic exp);
        check(tag, {31'd0, irq_o[idx]}, {31'd0, exp});
    endtask

    initial begin
        i_rst    = 1'b1;
        wb_adr_i = '0;
        wb_dat_i = '0;
        wb_we_i  = 1'b0;
        wb_sel_i = '0;
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check("reset_ack", {30'd0, wb_ack_o, wb_err_o}, 32'd0);
        check("reset_dat", wb_dat_o, 32'd0);
        check("reset_irq", {28'd0, irq_o}, 32'd0);
        check("rty_tied", {31'd0, wb_rty_o}, 32'd0);
        i_rst = 1'b0;

        // Reset state of every register
        for (int a = 0; a < 16; a++) rd("reset_reg", 6'(a), 32'd0);

        // Channel 1 periodic: RELOAD=3, PRESC=1, IE, EN; CTRL write edge is W
        wr(6'd5, 32'd3);
        wr(6'd4, 32'h0000_0105);                   // returns after W+1
        irq_is("ch1_irq_before", 1, 1'b0);
        @(posedge i_clk); #1;                      // after W+2: first tick expires COUNT=0
        irq_is("ch1_irq_first_exp", 1, 1'b1);
        wr(6'd7, 32'd1);                           // STAT clear at W+3
        check("ch1_irq_cleared", {31'd0, irq_at_ack[1]}, 32'd0);
        rd("ch1_count_2", 6'd6, 32'd2);            // sampled after W+4
        rd("ch1_count_1", 6'd6, 32'd1);            // after W+6
        irq_is("ch1_irq_mid", 1, 1'b0);
        rd("ch1_count_0", 6'd6, 32'd0);            // after W+8
        irq_is("ch1_irq_second_exp", 1, 1'b1);     // W+10, 8 cycles after W+2
        rd("ch1_count_reload", 6'd6, 32'd3);       // after W+10
        rd("ch1_stat", 6'd7, 32'd1);
        wr(6'd4, 32'd0);

        // Channel 0 one-shot: COUNT=5, ONESHOT|IE|EN, PRESC=0
        wr(6'd2, 32'd5);
        wr(6'd0, 32'h0000_0007);                   // returns after W+1
        irq_is("ch0_irq_w1", 0, 1'b0);
        repeat (4) @(posedge i_clk);
        #1;
        irq_is("ch0_irq_w5", 0, 1'b0);
        @(posedge i_clk); #1;
        irq_is("ch0_irq_w6", 0, 1'b1);
        rd("ch0_ctrl_en_cleared", 6'd0, 32'h0000_0006);
        rd("ch0_count_zero", 6'd2, 32'd0);
        repeat (3) @(posedge i_clk);
        #1;
        rd("ch0_count_holds", 6'd2, 32'd0);
        wr(6'd3, 32'd1);
        check("ch0_irq_at_clear", {31'd0, irq_at_ack[0]}, 32'd0);
        irq_is("ch0_irq_after_clear", 0, 1'b0);
        rd("ch0_stat_clear", 6'd3, 32'd0);

        // Channel 2 periodic RELOAD=0, PRESC=0: every edge expires; W1C must lose
        wr(6'd8, 32'h0000_0005);
        wr(6'd11, 32'd1);
        check("ch2_set_wins", {31'd0, irq_at_ack[2]}, 32'd1);
        rd("ch2_stat_set", 6'd11, 32'd1);
        wr(6'd8, 32'd0);
        wr(6'd11, 32'd1);
        rd("ch2_stat_clear_idle", 6'd11, 32'd0);
        irq_is("ch2_irq_off", 2, 1'b0);

        // Channel 3: COUNT write lands on a tick edge (PRESC=3, ticks at W+4, W+8)
        wr(6'd14, 32'd100);
        wr(6'd12, 32'h0000_0301);                  // returns after W+1
        repeat (2) @(posedge i_clk);
        #1;
        wr(6'd14, 32'h0000_1234);                  // accepted on tick edge W+4
        rd("ch3_write_wins", 6'd14, 32'h0000_1234);
        rd("ch3_no_tick_yet", 6'd14, 32'h0000_1234);
        rd("ch3_next_tick", 6'd14, 32'h0000_1233);
        wr(6'd12, 32'd0);
        wr(6'd14, 32'hAABB_CCDD);
        wr_sel(6'd14, 32'h1122_3344, 4'b0001);
        rd("ch3_byte0_only", 6'd14, 32'hAABB_CC44);
        wr(6'd13, 32'h0000_0055);
        rd("ch3_reload_val", 6'd13, 32'h0000_0055);
        rd("ch3_reload_keeps_count", 6'd14, 32'hAABB_CC44);
        wr(6'd12, 32'hFFFF_FFF8);
        rd("ch3_ctrl_unused_zero", 6'd12, 32'h0000_FF00);
        wr(6'd12, 32'd0);

        // Out-of-range channel 5 must not alias onto channel 1
        wr(6'd6, 32'h0000_0077);
        xfer(1'b1, 6'd22, 32'h0000_DEAD, 4'hF, 1'b1, q);
        check("err_wr_dat", q, 32'd0);
        xfer(1'b0, 6'd22, 32'd0, 4'hF, 1'b1, q);
        check("err_rd_dat", q, 32'd0);
        rd("err_no_alias", 6'd6, 32'h0000_0077);

        // Reset asserted while a read is pending
        wr(6'd1, 32'h0000_0099);
        rd("pre_rst_reload", 6'd1, 32'h0000_0099);
        wb_adr_i = 6'd1;
        wb_we_i  = 1'b0;
        wb_sel_i = 4'hF;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        i_rst    = 1'b1;
        @(posedge i_clk); #1;
        check("rst_no_ack", {30'd0, wb_ack_o, wb_err_o}, 32'd0);
        i_rst    = 1'b0;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        @(posedge i_clk); #1;
        check("rst_still_no_ack", {30'd0, wb_ack_o, wb_err_o}, 32'd0);
        rd("rst_reload_zero", 6'd1, 32'd0);
        rd("rst_count_zero", 6'd14, 32'd0);
        rd("rst_ch1_count_zero", 6'd6, 32'd0);
        check("rst_irq_zero", {28'd0, irq_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
